// File: rtl/sync_debounce_edge.sv
// -----------------------------------------------------------------------------
// sync_debounce_edge
//
// Purpose:
//   Debounces a 1-bit level that has already been synchronized into the clk
//   domain. A new level is accepted only after DEBOUNCE_CYCLES consecutive
//   samples at that level. The block produces:
//     - the filtered level
//     - one-cycle rise and fall strobes
//     - a one-cycle glitch strobe for an aborted candidate
//     - a saturating glitch counter for status reporting
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive equal samples needed to accept (>= 2)
//   GLITCH_CNT_W     width of o_glitch_cnt (>= 1)
//   INIT_LEVEL       level presented (and stable state entered) after reset
//
// Ports:
//   clk           in   clock, all logic on posedge
//   rst           in   synchronous reset, active-high
//   i_sig_sync    in   synchronized input level
//   i_cnt_clr     in   clears o_glitch_cnt on the next edge (beats increment)
//   o_level       out  debounced level
//   o_rise        out  1-cycle strobe, o_level went 0->1
//   o_fall        out  1-cycle strobe, o_level went 1->0
//   o_glitch      out  1-cycle strobe, candidate change aborted
//   o_glitch_cnt  out  saturating count of aborted candidates
// -----------------------------------------------------------------------------
module sync_debounce_edge #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter int   GLITCH_CNT_W    = 8,
    parameter logic INIT_LEVEL      = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_sig_sync,
    input  logic                    i_cnt_clr,
    output logic                    o_level,
    output logic                    o_rise,
    output logic                    o_fall,
    output logic                    o_glitch,
    output logic [GLITCH_CNT_W-1:0] o_glitch_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    // Count value held while sampling the last required candidate sample.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        CHK_HI,
        STABLE_HI,
        CHK_LO
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_level;
    logic                    r_rise;
    logic                    r_fall;
    logic                    r_glitch;
    logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

    logic w_glitch_evt;
    logic w_cnt_sat;

    // A candidate is aborted when the input returns to the stable level
    // while a check is in progress; this is the only glitch source.
    assign w_glitch_evt = ((r_state == CHK_HI) && !i_sig_sync) ||
                          ((r_state == CHK_LO) &&  i_sig_sync);
    assign w_cnt_sat    = &r_glitch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= INIT_LEVEL ? STABLE_HI : STABLE_LO;
            r_cnt        <= '0;
            r_level      <= INIT_LEVEL;
            r_rise       <= 1'b0;
            r_fall       <= 1'b0;
            r_glitch     <= 1'b0;
            r_glitch_cnt <= '0;
        end else begin
            // Strobes default low so each pulse lasts exactly one cycle.
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= w_glitch_evt;

            case (r_state)
                STABLE_LO: begin
                    if (i_sig_sync) begin
                        r_state <= CHK_HI;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                CHK_HI: begin
                    if (!i_sig_sync) begin
                        r_state <= STABLE_LO;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= STABLE_HI;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!i_sig_sync) begin
                        r_state <= CHK_LO;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                CHK_LO: begin
                    if (i_sig_sync) begin
                        r_state <= STABLE_HI;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= STABLE_LO;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            endcase

            // Clear takes priority over a same-cycle increment; the count
            // holds at all-ones instead of wrapping.
            if (i_cnt_clr) begin
                r_glitch_cnt <= '0;
            end else if (w_glitch_evt && !w_cnt_sat) begin
                r_glitch_cnt <= r_glitch_cnt + GLITCH_CNT_W'(1);
            end
        end
    end

    assign o_level      = r_level;
    assign o_rise       = r_rise;
    assign o_fall       = r_fall;
    assign o_glitch     = r_glitch;
    assign o_glitch_cnt = r_glitch_cnt;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// -----------------------------------------------------------------------------
// tb_sync_debounce_edge
//
// Two instances (INIT_LEVEL 0 and 1, DEBOUNCE_CYCLES=4, GLITCH_CNT_W=2) run
// side by side. Directed scenarios feed instance 1 the inverted stimulus of
// instance 0 so the falling path mirrors the rising path. A reference model
// tracks "samples seen away from the accepted level" per instance and derives
// every expected output from that.
// -----------------------------------------------------------------------------
module tb_sync_debounce_edge;

    localparam int DC   = 4;
    localparam int GW   = 2;
    localparam int CMAX = (1 << GW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    sig;
    logic          cnt_clr;
    logic [1:0]    level, rise, fall, glitch;
    logic [GW-1:0] gcnt [2];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic m_level  [2];
    int   m_run    [2];
    int   m_cnt    [2];
    logic m_rise   [2];
    logic m_fall   [2];
    logic m_glitch [2];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            sync_debounce_edge #(
                .DEBOUNCE_CYCLES(DC),
                .GLITCH_CNT_W   (GW),
                .INIT_LEVEL     ((gi == 1) ? 1'b1 : 1'b0)
            ) dut (
                .clk         (clk),
                .rst         (rst),
                .i_sig_sync  (sig[gi]),
                .i_cnt_clr   (cnt_clr),
                .o_level     (level[gi]),
                .o_rise      (rise[gi]),
                .o_fall      (fall[gi]),
                .o_glitch    (glitch[gi]),
                .o_glitch_cnt(gcnt[gi])
            );
        end
    endgenerate

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            assert (!$isunknown(sig)) else $error("input unknown while out of reset");
        end
    end

    function automatic logic [5:0] got_vec(input int d);
        return {level[d], rise[d], fall[d], glitch[d], gcnt[d]};
    endfunction

    function automatic logic [5:0] exp_vec(input int d);
        logic [GW-1:0] c;
        c = GW'(m_cnt[d]);
        return {m_level[d], m_rise[d], m_fall[d], m_glitch[d], c};
    endfunction

    // Drive one clock of stimulus, advance the model at the edge, and leave
    // the bench 1 time unit after the edge for sampling.
    task automatic step(input logic [1:0] s, input logic clr, input logic r);
        sig     = s;
        cnt_clr = clr;
        rst     = r;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_rise[d]   = 1'b0;
            m_fall[d]   = 1'b0;
            m_glitch[d] = 1'b0;
            if (r) begin
                m_level[d] = (d == 1);
                m_run[d]   = 0;
                m_cnt[d]   = 0;
            end else begin
                if (s[d] != m_level[d]) begin
                    m_run[d]++;
                    if (m_run[d] == DC) begin
                        m_level[d] = s[d];
                        if (s[d]) m_rise[d] = 1'b1;
                        else      m_fall[d] = 1'b1;
                        m_run[d] = 0;
                    end
                end else if (m_run[d] > 0) begin
                    m_glitch[d] = 1'b1;
                    if (m_cnt[d] < CMAX) m_cnt[d]++;
                    m_run[d] = 0;
                end
                if (clr) m_cnt[d] = 0;
            end
        end
        #1;
        if (r || (|rise) || (|fall) || (|glitch))
            $display("t=%0t rst=%b sig=%b clr=%b lvl=%b rise=%b fall=%b glitch=%b cnt0=%0d cnt1=%0d",
                     $time, r, s, clr, level, rise, fall, glitch, gcnt[0], gcnt[1]);
    endtask

    // Directed helper: instance 1 gets the mirror of instance 0
    task automatic dstep(input logic s, input logic clr, input logic r);
        step({~s, s}, clr, r);
    endtask

    task automatic test_reset();
        dstep(1'b1, 1'b0, 1'b1);
        dstep(1'b0, 1'b0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got_vec(d) !== exp_vec(d)) begin
                errors++;
                $display("FAIL reset dut%0d got=%b want=%b", d, got_vec(d), exp_vec(d));
            end
        end
        checks++;
        if (level !== 2'b10 || rise !== 2'b00 || fall !== 2'b00 || glitch !== 2'b00) begin
            errors++;
            $display("FAIL reset_levels got lvl=%b r=%b f=%b g=%b want lvl=10 strobes 00",
                     level, rise, fall, glitch);
        end
    endtask

    task automatic test_rise();
        dstep(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            dstep(1'b1, 1'b0, 1'b0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL rise dut%0d step %0d got=%b want=%b", d, i, got_vec(d), exp_vec(d));
                end
            end
            if (i == 2) begin
                checks++;
                if (level[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL rise_early got lvl=%b want 0", level[0]);
                end
            end
            if (i == 3) begin
                checks++;
                if (level[0] !== 1'b1 || rise[0] !== 1'b1 || fall[1] !== 1'b1 || gcnt[0] !== '0) begin
                    errors++;
                    $display("FAIL rise_4th got lvl=%b rise=%b fall1=%b cnt=%0d want 1 1 1 0",
                             level[0], rise[0], fall[1], gcnt[0]);
                end
            end
            if (i == 4) begin
                checks++;
                if (rise[0] !== 1'b0 || fall[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL rise_pulse_width got rise=%b fall1=%b want 0 0", rise[0], fall[1]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] pat;
        pat = 8'b1111_0111; // applied LSB first: 1,1,1,0 then 1,1,1,1
        dstep(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            dstep(pat[i], 1'b0, 1'b0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL glitch dut%0d step %0d got=%b want=%b", d, i, got_vec(d), exp_vec(d));
                end
            end
            if (i == 3) begin
                checks++;
                if (glitch[0] !== 1'b1 || gcnt[0] !== 2'd1 || level[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch_abort got g=%b cnt=%0d lvl=%b want 1 1 0",
                             glitch[0], gcnt[0], level[0]);
                end
            end
            if (i == 7) begin
                checks++;
                if (rise[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL glitch_then_rise got rise=%b want 1", rise[0]);
                end
            end
        end
    endtask

    task automatic test_saturate();
        int exp_cnt [5] = '{1, 2, 3, 3, 3};
        int pulses;
        pulses = 0;
        dstep(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            dstep(1'b1, 1'b0, 1'b0);
            dstep(1'b0, 1'b0, 1'b0);
            if (glitch[0] === 1'b1) pulses++;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL saturate dut%0d glitch %0d got=%b want=%b", d, i, got_vec(d), exp_vec(d));
                end
            end
            checks++;
            if (gcnt[0] !== GW'(exp_cnt[i])) begin
                errors++;
                $display("FAIL sat_count glitch %0d got=%0d want=%0d", i, gcnt[0], exp_cnt[i]);
            end
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL sat_pulses got=%0d want=5", pulses);
        end
        dstep(1'b1, 1'b0, 1'b0);
        dstep(1'b0, 1'b1, 1'b0);
        checks++;
        if (gcnt[0] !== '0 || gcnt[1] !== '0 || glitch[0] !== 1'b1) begin
            errors++;
            $display("FAIL clr_wins got cnt0=%0d cnt1=%0d g=%b want 0 0 1", gcnt[0], gcnt[1], glitch[0]);
        end
    endtask

    task automatic test_fall();
        dstep(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) dstep(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            dstep(1'b0, 1'b0, 1'b0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL fall dut%0d step %0d got=%b want=%b", d, i, got_vec(d), exp_vec(d));
                end
            end
            checks++;
            if (rise[0] !== 1'b0) begin
                errors++;
                $display("FAIL fall_no_rise step %0d got rise=%b want 0", i, rise[0]);
            end
            if (i == 3) begin
                checks++;
                if (fall[0] !== 1'b1 || level[0] !== 1'b0 || rise[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL fall_4th got fall=%b lvl=%b rise1=%b want 1 0 1",
                             fall[0], level[0], rise[1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        dstep(1'b0, 1'b0, 1'b1);
        dstep(1'b1, 1'b0, 1'b0);
        dstep(1'b0, 1'b0, 1'b0);   // glitch so the counter is nonzero
        dstep(1'b1, 1'b0, 1'b0);
        dstep(1'b1, 1'b0, 1'b0);   // checking with cnt=2
        dstep(1'b1, 1'b0, 1'b1);   // reset mid-check
        checks++;
        if (level !== 2'b10 || rise !== 2'b00 || fall !== 2'b00 || glitch !== 2'b00 ||
            gcnt[0] !== '0 || gcnt[1] !== '0) begin
            errors++;
            $display("FAIL reset_mid got lvl=%b r=%b f=%b g=%b cnt0=%0d cnt1=%0d want 10 00 00 00 0 0",
                     level, rise, fall, glitch, gcnt[0], gcnt[1]);
        end
        for (int i = 0; i < 4; i++) begin
            dstep(1'b1, 1'b0, 1'b0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL reset_mid dut%0d step %0d got=%b want=%b", d, i, got_vec(d), exp_vec(d));
                end
            end
            checks++;
            if (level[0] !== (i == 3) || level[1] !== (i != 3)) begin
                errors++;
                $display("FAIL reset_mid_full step %0d got lvl=%b want %b", i, level, (i == 3) ? 2'b01 : 2'b10);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] v;
        int         len [2];
        logic       clr, r;
        v      = 2'b00;
        len[0] = 0;
        len[1] = 0;
        dstep(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            for (int d = 0; d < 2; d++) begin
                if (len[d] == 0) begin
                    v[d]   = 1'($urandom_range(0, 1));
                    len[d] = $urandom_range(1, 6);
                end
                len[d]--;
            end
            clr = ($urandom_range(0, 19) == 0);
            r   = ($urandom_range(0, 99) == 0);
            step(v, clr, r);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d got=%b want=%b", d, i, got_vec(d), exp_vec(d));
                end
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        sig     = 2'b10;
        cnt_clr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_level[d]  = (d == 1);
            m_run[d]    = 0;
            m_cnt[d]    = 0;
            m_rise[d]   = 1'b0;
            m_fall[d]   = 1'b0;
            m_glitch[d] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_rise();
        test_glitch();
        test_saturate();
        test_fall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
